traffic_light_ctrl_n: RTL

- Parametrised two-road traffic-light controller. It succeeds the single-road fixed-timing controller.
- Generates its own 1 s tick from sys_clk and sequences road A and road B through green, yellow and all-red phases, with programmable durations.
- Adds a flashing-yellow night mode and a binary+BCD countdown that feeds the 4-digit display block directly.
- Sits under the board top, between the clock input and the display.

---
 rtl/traffic_light_ctrl_n_pkg.sv | 35 +++
 rtl/traffic_light_ctrl_n_tick_gen.sv | 42 ++++
 rtl/traffic_light_ctrl_n.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_n_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the two-road traffic-light controller.
//   state_e  : controller phases (3-bit encoding)
//   LAMP_*   : lamp patterns, bit order {red, yellow, green}
//   to_bcd2  : 0..99 binary value to two BCD digits {tens, units}
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    NIGHT  = 3'd6
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int REMAIN_W = 7;

  function automatic logic [7:0] to_bcd2(input logic [REMAIN_W-1:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Divides sys_clk down to the countdown tick. The counter runs
// 0..TICK_DIV-1 and tick is high for the single cycle in which the counter
// sits at TICK_DIV-1, so the first tick appears TICK_DIV cycles after reset
// release and the whole controller stays in the sys_clk domain.
// Ports:
//   sys_clk   in  system clock
//   sys_rst_n in  asynchronous active-low reset
//   tick      out one-cycle pulse every TICK_DIV cycles
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("tick_gen: TICK_DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt_p0;

  // Stage p0: free-running divider counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_p0 <= '0;
    end else if (cnt_p0 == CNT_LAST) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  assign tick = (cnt_p0 == CNT_LAST);

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_n
// Two-road traffic-light controller with programmable phase durations,
// flashing-yellow night mode and a binary + BCD countdown for the display.
// Optional pedestrian request support is compiled in with `define PED_REQ_EN.
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   night_en   in   request flashing-yellow mode, sampled on ticks
//   ped_req    in   pedestrian request pulse        (PED_REQ_EN only)
//   light_a    out  road A lamps {red,yellow,green}
//   light_b    out  road B lamps {red,yellow,green}
//   remain     out  ticks remaining in the current phase, binary
//   remain_bcd out  {tens,units} BCD of remain
//   tick       out  one-cycle pulse per countdown tick
//   ped_walk   out  walk signal during a serviced clearance (PED_REQ_EN only)
// ---------------------------------------------------------------------------
module traffic_light_ctrl_n
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int GREEN_T   = 25,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int PED_MIN_T = 5
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                night_en,
`ifdef PED_REQ_EN
  input  logic                ped_req,
  output logic                ped_walk,
`endif
  output logic [2:0]          light_a,
  output logic [2:0]          light_b,
  output logic [REMAIN_W-1:0] remain,
  output logic [7:0]          remain_bcd,
  output logic                tick
);

  if (GREEN_T < 1 || GREEN_T > 99) begin : g_bad_green
    $error("traffic_light_ctrl_n: GREEN_T must be in 1..99");
  end
  if (YELLOW_T < 1 || YELLOW_T > 99) begin : g_bad_yellow
    $error("traffic_light_ctrl_n: YELLOW_T must be in 1..99");
  end
  if (ALLRED_T < 1 || ALLRED_T > 99) begin : g_bad_allred
    $error("traffic_light_ctrl_n: ALLRED_T must be in 1..99");
  end
  if (PED_MIN_T < 1 || PED_MIN_T > GREEN_T) begin : g_bad_ped_min
    $error("traffic_light_ctrl_n: PED_MIN_T must be in 1..GREEN_T");
  end

  localparam logic [REMAIN_W-1:0] GREEN_D  = REMAIN_W'(GREEN_T);
  localparam logic [REMAIN_W-1:0] YELLOW_D = REMAIN_W'(YELLOW_T);
  localparam logic [REMAIN_W-1:0] ALLRED_D = REMAIN_W'(ALLRED_T);
  localparam logic [REMAIN_W-1:0] PED_D    = REMAIN_W'(PED_MIN_T);

  function automatic state_e next_phase(input state_e s);
    case (s)
      A_GRN:   return A_YEL;
      A_YEL:   return RED_AB;
      RED_AB:  return B_GRN;
      B_GRN:   return B_YEL;
      B_YEL:   return RED_BA;
      default: return A_GRN;
    endcase
  endfunction

  function automatic logic [REMAIN_W-1:0] phase_len(input state_e s);
    case (s)
      A_GRN, B_GRN: return GREEN_D;
      A_YEL, B_YEL: return YELLOW_D;
      default:      return ALLRED_D;
    endcase
  endfunction

  // {light_a, light_b} for the normal (non-night) phases
  function automatic logic [5:0] phase_lamps(input state_e s);
    case (s)
      A_GRN:   return {LAMP_GRN, LAMP_RED};
      A_YEL:   return {LAMP_YEL, LAMP_RED};
      B_GRN:   return {LAMP_RED, LAMP_GRN};
      B_YEL:   return {LAMP_RED, LAMP_YEL};
      default: return {LAMP_RED, LAMP_RED};
    endcase
  endfunction

  logic                tick_p0;
  state_e              state_p1;
  state_e              succ_st;
  logic [REMAIN_W-1:0] remain_p1;
  logic                flash_p1;
  logic [2:0]          light_a_p1;
  logic [2:0]          light_b_p1;
  logic                ped_short;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick_p0)
  );

  assign succ_st = next_phase(state_p1);

`ifdef PED_REQ_EN
  logic ped_pend_p1;
  logic ped_walk_p1;
  logic enter_red;
  logic leave_red;

  assign ped_short = (state_p1 == A_GRN || state_p1 == B_GRN) && ped_pend_p1
                     && (remain_p1 > PED_D);

  // Clearance is entered from a yellow that expires, or from NIGHT on exit.
  assign enter_red = tick_p0 && !night_en &&
                     ((state_p1 == NIGHT) ||
                      ((state_p1 == A_YEL || state_p1 == B_YEL) && remain_p1 == 7'd1));
  // Clearance is left when it expires or when night mode interrupts it.
  assign leave_red = tick_p0 && (state_p1 == RED_AB || state_p1 == RED_BA) &&
                     (night_en || remain_p1 == 7'd1);

  // Stage p1: pedestrian request bookkeeping. The pending request is consumed
  // when its clearance starts, so a request during the walk re-arms it for
  // the following clearance.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ped_pend_p1 <= 1'b0;
      ped_walk_p1 <= 1'b0;
    end else begin
      if (leave_red) begin
        ped_walk_p1 <= 1'b0;
      end else if (enter_red && ped_pend_p1) begin
        ped_walk_p1 <= 1'b1;
      end

      if (ped_req) begin
        ped_pend_p1 <= 1'b1;
      end else if (enter_red && ped_pend_p1) begin
        ped_pend_p1 <= 1'b0;
      end
    end
  end

  assign ped_walk = ped_walk_p1;
`else
  assign ped_short = 1'b0;
`endif

  // Stage p1: phase sequencer with registered lamps and countdown
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_p1   <= A_GRN;
      remain_p1  <= GREEN_D;
      flash_p1   <= 1'b0;
      light_a_p1 <= LAMP_GRN;
      light_b_p1 <= LAMP_RED;
    end else if (tick_p0) begin
      if (night_en && state_p1 != NIGHT) begin
        state_p1   <= NIGHT;
        remain_p1  <= '0;
        flash_p1   <= 1'b1;
        light_a_p1 <= LAMP_YEL;
        light_b_p1 <= LAMP_YEL;
      end else if (state_p1 == NIGHT) begin
        if (night_en) begin
          flash_p1   <= ~flash_p1;
          light_a_p1 <= flash_p1 ? LAMP_OFF : LAMP_YEL;
          light_b_p1 <= flash_p1 ? LAMP_OFF : LAMP_YEL;
        end else begin
          // Leaving night always goes through a full clearance first.
          state_p1   <= RED_BA;
          remain_p1  <= ALLRED_D;
          flash_p1   <= 1'b0;
          light_a_p1 <= LAMP_RED;
          light_b_p1 <= LAMP_RED;
        end
      end else if (remain_p1 == 7'd1) begin
        state_p1                 <= succ_st;
        remain_p1                <= phase_len(succ_st);
        {light_a_p1, light_b_p1} <= phase_lamps(succ_st);
      end else if (ped_short) begin
        remain_p1 <= PED_D;
      end else begin
        remain_p1 <= remain_p1 - 7'd1;
      end
    end
  end

  assign light_a    = light_a_p1;
  assign light_b    = light_b_p1;
  assign remain     = remain_p1;
  assign remain_bcd = to_bcd2(remain_p1);
  assign tick       = tick_p0;

endmodule
